blind_motion_sequencer: RTL

Motion controller for the motorised blind/window axis. It arbitrates between the manual 3-position switch and single-cycle automatic requests from the house scheduler, and debounces both end-of-travel switches. It enforces a stop-pause before any direction reversal and a travel timeout. Its `motor_cmd` output drives the `switch_pos` input of the stepper driver; the driver's own limit gating stays in place as a second layer.

---
 rtl/blind_motion_sequencer_if.sv | 25 ++
 rtl/blind_motion_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/blind_motion_sequencer_if.sv
// Signal bundle between the blind motion sequencer and the switches,
// scheduler and stepper driver around it.
interface blind_motion_sequencer_if;
    logic [1:0] manual_pos;
    logic       auto_req_up;
    logic       auto_req_down;
    logic       stop_Up;
    logic       stop_Down;
    logic       fault_clr;
    logic [1:0] motor_cmd;
    logic       busy;
    logic       at_top;
    logic       at_bottom;
    logic       fault;

    modport master (
        output manual_pos, auto_req_up, auto_req_down, stop_Up, stop_Down, fault_clr,
        input  motor_cmd, busy, at_top, at_bottom, fault
    );

    modport slave (
        input  manual_pos, auto_req_up, auto_req_down, stop_Up, stop_Down, fault_clr,
        output motor_cmd, busy, at_top, at_bottom, fault
    );
endinterface

// File: rtl/blind_motion_sequencer.sv
// Blind axis motion controller: manual/auto arbitration, limit debouncing,
// reversal dead time and travel timeout driving the stepper switch_pos input.
module blind_motion_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned REVERSE_DEAD    = 2_500_000,
    parameter int unsigned TRAVEL_TIMEOUT  = 1_000_000_000
) (
    input logic                     clk,
    input logic                     rst,
    blind_motion_sequencer_if.slave bus
);
    localparam logic [1:0]  CMD_HOLD    = 2'b00;
    localparam logic [1:0]  CMD_UP      = 2'b01;
    localparam logic [1:0]  CMD_DOWN    = 2'b10;
    localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] DEAD_LAST   = 32'(REVERSE_DEAD - 1);
    localparam logic [31:0] TRAVEL_LAST = 32'(TRAVEL_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_DEAD, S_FAULT} state_t;
    typedef enum logic {SRC_MANUAL, SRC_AUTO} src_t;

    logic [1:0]  manual_meta, manual_sync;
    logic [1:0]  limit_meta, limit_sync, limit_deb;  // bit 1 = stop_Up, bit 0 = stop_Down
    logic [31:0] deb_cnt [2];

    state_t      state;
    src_t        src;
    logic        rev_up, rev_manual;
    logic        pend_valid, pend_up;
    logic [31:0] travel, dead_cnt;
    logic [1:0]  motor_cmd;
    logic        busy, fault;

    logic at_top, at_bottom, both_limits;
    logic man_up, man_down, man_req;
    logic pulse_up, pulse_down, auto_valid, auto_up;
    logic req_up, req_down;

    // NOTE: sequential state is written with <= only, so every register samples
    // the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            manual_meta <= '0;
            manual_sync <= '0;
            // NOTE: limit stages reset to the released (high) level so the
            // debouncers do not see a phantom press while the pipes refill.
            limit_meta  <= '1;
            limit_sync  <= '1;
            limit_deb   <= '1;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            manual_meta <= bus.manual_pos;
            manual_sync <= manual_meta;
            limit_meta  <= {bus.stop_Up, bus.stop_Down};
            limit_sync  <= limit_meta;
            for (int i = 0; i < 2; i++) begin
                if (limit_sync[i] == limit_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    limit_deb[i] <= limit_sync[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign at_top      = ~limit_deb[1];
    assign at_bottom   = ~limit_deb[0];
    assign both_limits = at_top & at_bottom;

    assign man_up   = (manual_sync == 2'b01);
    assign man_down = (manual_sync == 2'b10);
    assign man_req  = man_up | man_down;

    // A fresh pulse is acted on in the cycle it arrives; the pending register
    // only carries requests that arrive while the reversal pause is running.
    assign pulse_up   = bus.auto_req_up & ~bus.auto_req_down;
    assign pulse_down = bus.auto_req_down & ~bus.auto_req_up;
    assign auto_valid = pulse_up | pulse_down | pend_valid;
    assign auto_up    = (pulse_up | pulse_down) ? pulse_up : pend_up;
    assign req_up     = man_up   | (~man_req & auto_valid & auto_up);
    assign req_down   = man_down | (~man_req & auto_valid & ~auto_up);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            src        <= SRC_AUTO;
            rev_up     <= 1'b0;
            rev_manual <= 1'b0;
            pend_valid <= 1'b0;
            pend_up    <= 1'b0;
            travel     <= '0;
            dead_cnt   <= '0;
            motor_cmd  <= CMD_HOLD;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            if (state != S_DEAD || man_req || both_limits) begin
                pend_valid <= 1'b0;
            end else if (pulse_up || pulse_down) begin
                pend_valid <= 1'b1;
                pend_up    <= pulse_up;
            end else if (pend_valid && (pend_up ? at_top : at_bottom)) begin
                pend_valid <= 1'b0;
            end

            travel   <= (travel == '1) ? travel : travel + 32'd1;
            dead_cnt <= (state == S_DEAD) ? dead_cnt + 32'd1 : '0;

            if (both_limits) begin
                state <= S_FAULT; motor_cmd <= CMD_HOLD; busy <= 1'b0; fault <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req_up && !at_top) begin
                            state <= S_UP; motor_cmd <= CMD_UP; busy <= 1'b1;
                            travel <= '0; src <= man_req ? SRC_MANUAL : SRC_AUTO;
                        end else if (req_down && !at_bottom) begin
                            state <= S_DOWN; motor_cmd <= CMD_DOWN; busy <= 1'b1;
                            travel <= '0; src <= man_req ? SRC_MANUAL : SRC_AUTO;
                        end
                    end
                    S_UP, S_DOWN: begin
                        if (state == S_UP ? at_top : at_bottom) begin
                            state <= S_IDLE; motor_cmd <= CMD_HOLD; busy <= 1'b0;
                        end else if (travel == TRAVEL_LAST) begin
                            state <= S_FAULT; motor_cmd <= CMD_HOLD; busy <= 1'b0; fault <= 1'b1;
                        end else if (state == S_UP ? req_down : req_up) begin
                            state <= S_DEAD; motor_cmd <= CMD_HOLD;
                            rev_up <= (state == S_DOWN); rev_manual <= man_req;
                        end else if (src == SRC_MANUAL && !man_req) begin
                            state <= S_IDLE; motor_cmd <= CMD_HOLD; busy <= 1'b0;
                        end else if (state == S_UP ? man_up : man_down) begin
                            src <= SRC_MANUAL;
                        end
                    end
                    S_DEAD: begin
                        if (rev_manual && !man_req) begin
                            state <= S_IDLE; busy <= 1'b0;
                        end else if (dead_cnt == DEAD_LAST) begin
                            if (rev_up ? at_top : at_bottom) begin
                                state <= S_IDLE; busy <= 1'b0;
                            end else begin
                                state     <= rev_up ? S_UP : S_DOWN;
                                motor_cmd <= rev_up ? CMD_UP : CMD_DOWN;
                                travel    <= '0;
                                src       <= rev_manual ? SRC_MANUAL : SRC_AUTO;
                            end
                        end
                    end
                    S_FAULT: begin
                        if (bus.fault_clr && !man_req) begin
                            state <= S_IDLE; fault <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE; motor_cmd <= CMD_HOLD; busy <= 1'b0; fault <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.motor_cmd = motor_cmd;
    assign bus.busy      = busy;
    assign bus.fault     = fault;
    assign bus.at_top    = at_top;
    assign bus.at_bottom = at_bottom;
endmodule
